// File: rtl/multi_prescaler_if.sv
// Control and status bundle of the multi-channel prescaler.
// The master side drives the configuration and enables, and the slave side returns the pulses.
`timescale 1ns/1ps
interface multi_prescaler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] ch_oneshot;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              sync_restart;
    logic [NUM_CH-1:0] en_pulse;
    logic [NUM_CH-1:0] en_pulse_d;
    logic [NUM_CH-1:0] ch_done;

    modport master (
        output ch_enable, ch_oneshot, cfg_we, cfg_ch, cfg_div, sync_restart,
        input  en_pulse, en_pulse_d, ch_done
    );

    modport slave (
        input  ch_enable, ch_oneshot, cfg_we, cfg_ch, cfg_div, sync_restart,
        output en_pulse, en_pulse_d, ch_done
    );
endinterface

// File: rtl/multi_prescaler.sv
// Multi-channel clock-enable generator: per-channel programmable divider with shadowed reload,
// one-shot mode, global phase-align restart and a delayed copy of every enable pulse.
`timescale 1ns/1ps
module multi_prescaler #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DLY     = 1,
    parameter int DEF_DIV = 499
) (
    input  logic              clk,
    input  logic              resetN,
    multi_prescaler_if.slave  bus
);
    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

    logic [NUM_CH-1:0] w_en_pulse;
    logic [NUM_CH-1:0] w_done;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_active_div;
        logic [CNT_W-1:0] r_shadow_div;
        logic             r_en_pulse;
        logic             r_done;
        logic             w_wr;
        logic             w_term;
        logic [CNT_W-1:0] w_shadow_nxt;

        // A write landing on the terminal edge must already feed the next period.
        assign w_wr         = bus.cfg_we && (bus.cfg_ch == CH_W'(g));
        assign w_shadow_nxt = w_wr ? bus.cfg_div : r_shadow_div;
        assign w_term       = (r_cnt >= r_active_div);

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_cnt        <= '0;
                r_active_div <= DEF_VAL;
                r_shadow_div <= DEF_VAL;
                r_en_pulse   <= 1'b0;
                r_done       <= 1'b0;
            end else begin
                r_shadow_div <= w_shadow_nxt;
                if (!bus.ch_enable[g]) begin
                    r_cnt        <= '0;
                    r_en_pulse   <= 1'b0;
                    r_done       <= 1'b0;
                    r_active_div <= w_shadow_nxt;
                end else if (bus.sync_restart) begin
                    r_cnt      <= '0;
                    r_en_pulse <= 1'b0;
                end else if (r_done) begin
                    r_en_pulse <= 1'b0;
                end else if (w_term) begin
                    r_cnt        <= '0;
                    r_en_pulse   <= 1'b1;
                    r_active_div <= w_shadow_nxt;
                    if (bus.ch_oneshot[g]) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_cnt      <= r_cnt + CNT_W'(1);
                    r_en_pulse <= 1'b0;
                end
            end
        end

        assign w_en_pulse[g] = r_en_pulse;
        assign w_done[g]     = r_done;
    end

    // Delay pipe ignores ch_enable so pulses already in flight still reach the DPRAM writer.
    logic [NUM_CH-1:0] r_dly_p [DLY];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < DLY; k++) begin
                r_dly_p[k] <= '0;
            end
        end else begin
            r_dly_p[0] <= w_en_pulse;
            for (int k = 1; k < DLY; k++) begin
                r_dly_p[k] <= r_dly_p[k-1];
            end
        end
    end

    assign bus.en_pulse   = w_en_pulse;
    assign bus.en_pulse_d = r_dly_p[DLY-1];
    assign bus.ch_done    = w_done;
endmodule

// File: tb/tb_multi_prescaler.sv
// Bench for multi_prescaler: expected pulse steps are queued per stimulus and matched as pulses appear.
`timescale 1ns/1ps
module tb_multi_prescaler;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    typedef struct {
        int ch;
        int div;
        bit oneshot;
        int n;
        int first;
        int period;
        bit exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic resetN;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_q[$];
    logic [NUM_CH-1:0] prev_en = '0;
    vec_t vecs[6];

    multi_prescaler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    multi_prescaler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DLY(1), .DEF_DIV(499)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One clock edge; outputs sampled 1 ns later. en_pulse_d must be last step's en_pulse.
    task automatic step();
        @(posedge clk);
        #1;
        check("en_pulse_d", 32'(bus.en_pulse_d), 32'(prev_en));
        prev_en = bus.en_pulse;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN           = 1'b0;
        bus.ch_enable    = '0;
        bus.ch_oneshot   = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_ch       = '0;
        bus.cfg_div      = '0;
        bus.sync_restart = 1'b0;
        prev_en          = '0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic push(input int s, input int ch);
        exp_q.push_back(s * 8 + ch);
    endtask

    // Runs n edges; optional cfg write and sync_restart on a chosen edge (0 = none).
    task automatic run_window(input int n, input int wr_step, input int wr_ch, input int wr_div,
                              input int rs_step);
        int e;
        for (int s = 1; s <= n; s++) begin
            bus.cfg_we       = (s == wr_step);
            bus.cfg_ch       = wr_ch[CH_W-1:0];
            bus.cfg_div      = wr_div[CNT_W-1:0];
            bus.sync_restart = (s == rs_step);
            step();
            bus.cfg_we       = 1'b0;
            bus.sync_restart = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.en_pulse[c]) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pulse: unexpected pulse ch %0d at step %0d, none required", c, s);
                    end else begin
                        e = exp_q.pop_front();
                        if (e != s * 8 + c) begin
                            n_fail++;
                            $display("FAIL pulse: got ch %0d step %0d, expected ch %0d step %0d",
                                     c, s, e % 8, e / 8);
                        end
                    end
                end
            end
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing: %0d pulses not seen, next expected ch %0d step %0d",
                     exp_q.size(), exp_q[0] % 8, exp_q[0] / 8);
            exp_q.delete();
        end
    endtask

    task automatic write_div(input int ch, input int div);
        run_window(1, 1, ch, div, 0);
    endtask

    initial begin
        vecs[0] = '{ch: 0, div: -1, oneshot: 1'b0, n: 1001, first: 500, period: 500, exp_done: 1'b0};
        vecs[1] = '{ch: 1, div: 3,  oneshot: 1'b0, n: 20,   first: 4,   period: 4,   exp_done: 1'b0};
        vecs[2] = '{ch: 2, div: 0,  oneshot: 1'b0, n: 6,    first: 1,   period: 1,   exp_done: 1'b0};
        vecs[3] = '{ch: 3, div: 9,  oneshot: 1'b1, n: 40,   first: 10,  period: 0,   exp_done: 1'b1};
        vecs[4] = '{ch: 0, div: 7,  oneshot: 1'b0, n: 30,   first: 8,   period: 8,   exp_done: 1'b0};
        vecs[5] = '{ch: 3, div: 1,  oneshot: 1'b0, n: 7,    first: 2,   period: 2,   exp_done: 1'b0};

        // Reset state, checked while resetN is held low
        resetN           = 1'b0;
        bus.ch_enable    = '0;
        bus.ch_oneshot   = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_ch       = '0;
        bus.cfg_div      = '0;
        bus.sync_restart = 1'b0;
        repeat (3) @(negedge clk);
        check("rst en_pulse", 32'(bus.en_pulse), 32'h0);
        check("rst en_pulse_d", 32'(bus.en_pulse_d), 32'h0);
        check("rst ch_done", 32'(bus.ch_done), 32'h0);
        resetN = 1'b1;

        // Table: each vector runs one channel alone from a disabled start
        foreach (vecs[i]) begin
            bus.ch_enable  = '0;
            bus.ch_oneshot = '0;
            step();
            if (vecs[i].div >= 0) write_div(vecs[i].ch, vecs[i].div);
            bus.ch_oneshot[vecs[i].ch] = vecs[i].oneshot;
            bus.ch_enable[vecs[i].ch]  = 1'b1;
            if (vecs[i].period == 0) begin
                push(vecs[i].first, vecs[i].ch);
            end else begin
                for (int t = vecs[i].first; t <= vecs[i].n; t += vecs[i].period) push(t, vecs[i].ch);
            end
            run_window(vecs[i].n, 0, 0, 0, 0);
            check("vec ch_done", 32'(bus.ch_done), 32'(vecs[i].exp_done) << vecs[i].ch);
        end
        bus.ch_enable  = '0;
        bus.ch_oneshot = '0;
        step();

        // div=0 runs continuously, and drops the next clk after ch_enable falls
        bus.ch_enable = 4'b0100;
        for (int s = 1; s <= 5; s++) push(s, 2);
        run_window(5, 0, 0, 0, 0);
        bus.ch_enable = '0;
        step();
        check("div0 off", 32'(bus.en_pulse), 32'h0);

        // Reload mid-period: write at counter 100, then at the terminal edge
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.ch_enable = 4'b0010;
            push(500, 1); push(504, 1); push(508, 1); push(512, 1);
            run_window(512, (k == 0) ? 101 : 500, 1, 3, 0);
        end

        // One-shot and re-arm
        do_reset();
        write_div(3, 9);
        bus.ch_oneshot = 4'b1000;
        bus.ch_enable  = 4'b1000;
        push(10, 3);
        run_window(30, 0, 0, 0, 0);
        check("oneshot done", 32'(bus.ch_done), 32'h8);
        bus.ch_enable = '0;
        step();
        check("rearm done clr", 32'(bus.ch_done), 32'h0);
        bus.ch_enable = 4'b1000;
        push(10, 3);
        run_window(20, 0, 0, 0, 0);
        check("rearm done", 32'(bus.ch_done), 32'h8);
        bus.ch_enable  = '0;
        bus.ch_oneshot = '0;
        step();

        // sync_restart aligns ch0 (div 9) and ch1 (div 4)
        write_div(0, 9);
        write_div(1, 4);
        bus.ch_enable = 4'b0001;
        run_window(3, 0, 0, 0, 0);
        bus.ch_enable = 4'b0011;
        push(5, 1); push(7, 0); push(10, 1); push(20, 1); push(25, 0);
        push(25, 1); push(30, 1); push(35, 0); push(35, 1);
        run_window(36, 0, 0, 0, 15);
        bus.ch_enable = '0;
        step();

        // Async reset while a pulse is entering the delay pipe
        do_reset();
        write_div(0, 2);
        bus.ch_enable = 4'b0001;
        push(3, 0);
        run_window(3, 0, 0, 0, 0);
        resetN = 1'b0;
        #1;
        check("async en_pulse", 32'(bus.en_pulse), 32'h0);
        check("async en_pulse_d", 32'(bus.en_pulse_d), 32'h0);
        check("async ch_done", 32'(bus.ch_done), 32'h0);
        prev_en = '0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        push(500, 0); push(1000, 0);
        run_window(1001, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
